// File: rtl/ppu_vram_arb.sv
// Arbiter for the PPU's single VRAM port: renderer fetches vs. one buffered 0x2007 access.
// Define PPU_VRAM_ARB_STARVE_EN to build the wait counter and FORCE state (starvation guard).
module ppu_vram_arb #(
   parameter int unsigned STARVE_MAX = 16
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rend_active_in,
   input  logic        rend_req_in,
   input  logic [13:0] rend_a_in,
   input  logic        ri_rd_in,
   input  logic        ri_wr_in,
   input  logic [13:0] ri_a_in,
   input  logic [7:0]  ri_d_in,
   input  logic [7:0]  vram_d_in,
   output logic [13:0] vram_a_out,
   output logic [7:0]  vram_d_out,
   output logic        vram_wr_out,
   output logic        rend_ack_out,
   output logic [7:0]  ri_rd_d_out,
   output logic        ri_rd_vld_out,
   output logic        ri_busy_out,
   output logic        ri_drop_out
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_FORCE = 2'd2} state_t;

   state_t      r_state, w_next;
   logic        r_pend_wr;
   logic [13:0] r_pend_a;
   logic [7:0]  r_pend_d;
   logic        r_rd_inflight;
   logic [7:0]  r_rd_d;
   logic        r_rd_vld;
   logic        r_drop;

   logic w_ri_req, w_ri_grant, w_capture, w_drop;

   assign w_ri_req = ri_rd_in | ri_wr_in;

   always_comb begin
      w_ri_grant = 1'b0;
      case (r_state)
         S_WAIT:  w_ri_grant = ~rend_active_in | ~rend_req_in;
         S_FORCE: w_ri_grant = 1'b1;
         default: w_ri_grant = 1'b0;
      endcase
   end

   // The buffer frees on a grant edge, so a request on the grant cycle still fits.
   assign w_capture = w_ri_req & ((r_state == S_IDLE) | w_ri_grant);
   assign w_drop    = w_ri_req & ~w_capture;

`ifdef PPU_VRAM_ARB_STARVE_EN
   logic [7:0] r_wait_cnt;
   logic       w_cnt_hit;

   assign w_cnt_hit = ({1'b0, r_wait_cnt} + 9'd1) >= 9'(STARVE_MAX);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         r_wait_cnt <= 8'd0;
      else if (w_ri_grant)
         r_wait_cnt <= 8'd0;
      else if (r_state == S_WAIT && r_wait_cnt != 8'hFF)
         r_wait_cnt <= r_wait_cnt + 8'd1;
   end
`else
   logic w_unused_starve;
   assign w_unused_starve = (STARVE_MAX > 0);
`endif

   // State register
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_ri_req) w_next = S_WAIT;
         S_WAIT: begin
            if (w_ri_grant)
               w_next = w_ri_req ? S_WAIT : S_IDLE;
`ifdef PPU_VRAM_ARB_STARVE_EN
            else if (w_cnt_hit)
               w_next = S_FORCE;
`endif
         end
         S_FORCE: w_next = w_ri_req ? S_WAIT : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      vram_a_out   = rend_a_in;
      vram_d_out   = 8'h00;
      vram_wr_out  = 1'b0;
      rend_ack_out = 1'b0;
      if (w_ri_grant) begin
         vram_a_out  = r_pend_a;
         vram_wr_out = r_pend_wr;
         vram_d_out  = r_pend_wr ? r_pend_d : 8'h00;
      end else begin
         rend_ack_out = rend_req_in & rend_active_in;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_pend_wr <= 1'b0;
         r_pend_a  <= 14'd0;
         r_pend_d  <= 8'd0;
      end else if (w_capture) begin
         r_pend_wr <= ri_wr_in;
         r_pend_a  <= ri_a_in;
         r_pend_d  <= ri_d_in;
      end
   end

   // Read data arrives the cycle after the address, so it is captured one edge after grant.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_rd_inflight <= 1'b0;
         r_rd_d        <= 8'h00;
         r_rd_vld      <= 1'b0;
         r_drop        <= 1'b0;
      end else begin
         r_rd_inflight <= w_ri_grant & ~r_pend_wr;
         r_rd_vld      <= r_rd_inflight;
         r_drop        <= w_drop;
         if (r_rd_inflight) r_rd_d <= vram_d_in;
      end
   end

   assign ri_rd_d_out   = r_rd_d;
   assign ri_rd_vld_out = r_rd_vld;
   assign ri_busy_out   = (r_state != S_IDLE);
   assign ri_drop_out   = r_drop;

endmodule

// File: doc/ppu_vram_arb.md
# ppu_vram_arb

Arbiter for the PPU's single VRAM port, shared between the rendering fetch pipeline and the CPU register interface's 0x2007 accesses. Register-interface (RI) accesses are held in a one-entry pending buffer and issued on cycles the renderer leaves idle. An optional starvation guard forces an RI slot. Read data returns to the RI as a registered byte with a valid strobe; this byte refills the 0x2007 read buffer.

## Interface
- STARVE_MAX, 16: RI wait cycles before the starvation guard forces a grant (guard builds only; range 2..255).
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous, active-high
- rend_active_in  input  1  renderer owns the bus this frame region (rendering enabled, visible/pre-render line)
- rend_req_in  input  1  renderer fetch request this cycle
- rend_a_in  input  14  renderer fetch address
- ri_rd_in  input  1  one-cycle RI read request (0x2007 read)
- ri_wr_in  input  1  one-cycle RI write request (0x2007 write)
- ri_a_in  input  14  RI VRAM address, sampled with request
- ri_d_in  input  8  RI write data, sampled with request
- vram_d_in  input  8  VRAM read data; synchronous RAM, valid the cycle after address
- vram_a_out  output  14  VRAM address
- vram_d_out  output  8  VRAM write data
- vram_wr_out  output  1  VRAM write enable
- rend_ack_out  output  1  renderer fetch granted this cycle
- ri_rd_d_out  output  8  last RI read byte (held)
- ri_rd_vld_out  output  1  one-cycle strobe: ri_rd_d_out updated
- ri_busy_out  output  1  pending RI access not yet issued
- ri_drop_out  output  1  one-cycle strobe: RI request lost (buffer full)

## Operation
- States: IDLE (no pending), WAIT (pending, renderer busy), FORCE (guard build only). A separate rd_inflight flag tracks issued reads.
- Capture: an ri_rd_in or ri_wr_in pulse in IDLE latches type, address and data into the pending buffer and moves to WAIT. Both high together: the write wins.
- Grant rule, evaluated each cycle in WAIT:
  - If rend_active_in=0 or rend_req_in=0, RI is granted. vram_a_out=pending address; vram_wr_out=1 for a write. Next state IDLE.
  - Otherwise the renderer is granted: rend_ack_out=1, vram_a_out=rend_a_in, and the wait counter increments.
- Renderer: in IDLE, rend_ack_out=rend_req_in & rend_active_in and vram_a_out=rend_a_in. An unacked renderer must hold its request.
- FORCE: the wait counter reaching STARVE_MAX moves WAIT to FORCE. FORCE grants RI unconditionally with rend_ack_out=0 for one cycle, then returns to IDLE. The counter clears on every RI grant.
- Buffer full: a request arriving in WAIT or FORCE is discarded and ri_drop_out pulses. The pending entry is unchanged.
- Request on grant cycle: a request arriving on the grant cycle is captured, because the buffer frees on that edge. Next state is WAIT.
- Read return: an RI read grant sets rd_inflight. On the following edge, vram_d_in is captured into ri_rd_d_out and ri_rd_vld_out pulses.
- Idle bus: vram_d_out=pending data on an RI write grant, else 0. vram_a_out=rend_a_in when nothing is granted.
- Counter: 8-bit, saturating.

## Timing
- Reset values: state IDLE, pending cleared, counter 0, rd_inflight 0. Outputs: vram_a_out=rend_a_in, vram_d_out=0, vram_wr_out=0, rend_ack_out=0, ri_rd_d_out=0x00, ri_rd_vld_out=0, ri_busy_out=0, ri_drop_out=0.
- Uncontended RI write: request at edge E0; vram_wr_out is high in the cycle after E0; the RAM commits at E1.
- Uncontended RI read: request at E0; address issued in cycle E0..E1; RAM data available after E1; captured at E2; ri_rd_vld_out high in cycle E2..E3. Latency is two edges after capture.
- ri_busy_out is registered: high from the capture edge until the grant edge.
- rend_ack_out, vram_a_out and vram_wr_out are combinational from state and inputs. All strobes last exactly one cycle.
- Asynchronous reset mid-access: an in-flight read is abandoned with no ri_rd_vld_out, the pending entry is lost, and outputs return to reset values immediately.

## Configuration
- PPU_VRAM_ARB_STARVE_EN defined: the wait counter and FORCE state are built, so the worst-case RI latency while rendering is STARVE_MAX+1 cycles.
- Not defined: no counter and no FORCE state. The renderer always wins, and RI waits indefinitely while the renderer requests every cycle.

## Test plan
- rend_active_in=0, write 0x55 to 0x2400 -> vram_wr_out=1 with vram_a_out=0x2400 and vram_d_out=0x55 one cycle after the request; ri_busy_out is high for exactly one cycle.
- rend_active_in=0, VRAM[0x0123]=0xA7, read 0x0123 -> ri_rd_vld_out pulses with ri_rd_d_out=0xA7 on the second edge after capture.
- Renderer requests continuously for 5 cycles, RI write pending -> renderer is acked for 5 cycles; RI is granted on the first cycle rend_req_in=0.
- STARVE_EN with STARVE_MAX=4, renderer requests continuously -> RI is granted in the 5th wait cycle with rend_ack_out=0 for that cycle only.
- Second request while WAIT -> ri_drop_out pulses once; the first request's address and data are the ones issued.
- rst_in asserted between a read grant and data return -> no ri_rd_vld_out; all outputs take reset values asynchronously.
